spi_rx_deserializer: RTL and testbench
======================================

# spi_rx_deserializer

Receive-side partner of the SPI serializer. Samples the MISO line (`rx`) on the SPI clock that the SPI controller drives out, shifts in words of 1–32 bits framed by chip-select, and presents each completed word on a one-entry valid/ready output. That output feeds the RX FIFO, whose `rxfe`/`rxff`/`rxfo` flags appear in the STATUS register.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flop depth of the synchronizer on `rx`, `sclk` and `cs_n`. Legal range 2–3.
- `W`, default 32: maximum word width and width of `data_out`.

Ports:
- `clk`  in  1  system clock. Reset is `reset`, synchronous, active-high; the clock is `clk`.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  CONTROL[15]. Low aborts any partial word and holds the block in IDLE.
- `word_len`  in  5  CONTROL[4:0]. The word is `word_len + 1` bits.
- `sample_falling`  in  1  0: sample on the `sclk` rising edge; 1: sample on the falling edge.
- `sclk`  in  1  SPI clock (the baud output).
- `cs_n`  in  1  frame select, active low.
- `rx`  in  1  serial data in, MSB first.
- `data_out`  out  W  received word, right-aligned, upper bits zero.
- `data_valid`  out  1  `data_out` holds an unconsumed word.
- `data_ready`  in  1  consumer (RX FIFO not full) accepts the word.
- `overflow`  out  1  sticky flag: a word was dropped.
- `ov_clear`  in  1  one-cycle W1C pulse that clears `overflow`.
- `busy`  out  1  high in SHIFT.
- `bits_left`  out  6  debug copy of the bit counter.

## Operation
- The inputs `sclk`, `cs_n` and `rx` pass through identical `SYNC_STAGES` pipelines, which keeps them phase-aligned with each other.
- Sample edge: `sclk_s != sclk_s_d`, and the new level is 1 when `sample_falling` = 0, or 0 when it is 1.
- State machine, 2 states:
  - IDLE → SHIFT when `enable` && `cs_n_s` == 0. On entry: `bits_left` ← `word_len` + 1, shift register cleared.
  - SHIFT, on each sample edge: shift ← {shift[W-2:0], `rx_s`}; `bits_left` decrements.
  - SHIFT, when `bits_left` reaches 0: the word completes and `bits_left` reloads to `word_len` + 1. The state stays SHIFT, which supports back-to-back words inside one frame.
  - SHIFT → IDLE when `cs_n_s` == 1 or `enable` == 0. Any partial word is discarded, nothing is pushed, and `overflow` is unchanged.
- Word completion: on the clk edge after the final shift, `data_out` ← shift register and `data_valid` ← 1.
- Handshake: the word transfers on a cycle with `data_valid` && `data_ready`. `data_valid` drops the following cycle unless a new word loads in that same cycle.
- Boundary cases:
  - Word completes while `data_valid` = 1 and `data_ready` = 0: the new word is dropped, the old word is kept, and `overflow` ← 1.
  - Word completes on the same cycle the pending word is accepted: no overflow, and the new word loads.
  - `ov_clear` on the same cycle a new overflow occurs: set wins.
  - `enable` low: the pending output word is kept and `data_valid` is unchanged.
  - `word_len` is latched at SHIFT entry and at each reload. Mid-word changes take effect at the next word.
- Reset values: `data_out` = 0, `data_valid` = 0, `overflow` = 0, `busy` = 0, `bits_left` = 0, state IDLE, synchronizers cleared to `cs_n` = 1, `sclk` = 0, `rx` = 0.
- Reset mid-word: the partial word and the pending word are both lost.

## Timing
- Latency: `data_valid` rises `SYNC_STAGES` + 2 clk cycles after the clk edge that first registers the final raw sample edge.
- `sclk` half-period must be at least 2 clk cycles, so that every edge is seen once.
- Throughput: one word per `word_len` + 1 sample edges. The consumer must accept within one word time to avoid overflow.
- All outputs are registered. There is no combinational path from `data_ready` to `data_valid`.

## Structure
- Shared package `spi_pkg` contains:
  - state enum (IDLE, SHIFT);
  - register addresses DATA = 0, STATUS = 1, CONTROL = 2, BRD = 3;
  - CONTROL bit constants: ENABLE = 15, CS_AUTO = 5, CS0_EN = 9, WORD_LEN = [4:0];
  - STATUS bit positions: RXFO = 0, RXFF = 1, RXFE = 2, TXFO = 3, TXFF = 4, TXFE = 5.
- One sub-module, `sync_ff`: a parameterized-depth, 1-bit synchronizer, instantiated three times.

## Test plan
- 8-bit word: `word_len` = 7, `sample_falling` = 0, `sclk` half-period 4 clk, `rx` drives 0xA5 MSB first, `cs_n` low for 8 edges → `data_out` = 0x000000A5, `data_valid` high exactly `SYNC_STAGES` + 2 cycles after the final edge, with `data_ready` = 1 one-cycle pulse.
- 32-bit back-to-back: `word_len` = 31, two words 0xDEADBEEF then 0x12345678 in one frame → two handshakes in order, `overflow` = 0.
- Overflow: `data_ready` held 0, two 8-bit words 0x11 then 0x22 → `data_out` stays 0x11 and `overflow` = 1. Then `ov_clear` pulse → `overflow` = 0 and `data_out` still 0x11.
- Abort: `cs_n` rises after 5 of 8 bits → no `data_valid`, state IDLE, `bits_left` reloads on the next frame. A following full word 0x3C is received correctly.
- Edge select: `sample_falling` = 1, `rx` changes on rising edges, word 0x5A → `data_out` = 0x5A. Then `reset` asserted mid-word → all outputs at reset values on the next cycle.
- Simultaneous events: a word completes on the same cycle as the `data_ready` accept → new word loaded, no overflow. A new overflow coincides with `ov_clear` → `overflow` = 1.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: receiver state encoding, register map and bit positions
// used by the SPI controller and its serializer/deserializer blocks.
package spi_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [1:0] DATA    = 2'd0;
    localparam logic [1:0] STATUS  = 2'd1;
    localparam logic [1:0] CONTROL = 2'd2;
    localparam logic [1:0] BRD     = 2'd3;

    localparam int ENABLE       = 15;
    localparam int CS_AUTO      = 5;
    localparam int CS0_EN       = 9;
    localparam int WORD_LEN_MSB = 4;
    localparam int WORD_LEN_LSB = 0;

    localparam int RXFO = 0;
    localparam int RXFF = 1;
    localparam int RXFE = 2;
    localparam int TXFO = 3;
    localparam int TXFF = 4;
    localparam int TXFE = 5;

    // CONTROL.WORD_LEN holds the word size minus one.
    function automatic logic [5:0] word_bits(input logic [4:0] len);
        return {1'b0, len} + 6'd1;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Single-bit synchronizer of configurable depth with a selectable reset level,
// so idle-high lines such as chip-select come out of reset inactive.
module sync_ff #(
    parameter int   DEPTH     = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] chain_q;
    logic [DEPTH-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[DEPTH-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chain_q <= {DEPTH{RESET_VAL}};
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[DEPTH-1];

endmodule

// File: rtl/spi_rx_deserializer.sv
// SPI receive deserializer: synchronizes sclk/cs_n/rx, shifts in 1-32 bit words
// MSB first inside a chip-select frame and offers each word on a one-entry valid/ready port.
module spi_rx_deserializer
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int W           = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [4:0]   word_len,
    input  logic         sample_falling,
    input  logic         sclk,
    input  logic         cs_n,
    input  logic         rx,
    output logic [W-1:0] data_out,
    output logic         data_valid,
    input  logic         data_ready,
    output logic         overflow,
    input  logic         ov_clear,
    output logic         busy,
    output logic [5:0]   bits_left
);

    logic sclk_s;
    logic cs_n_s;
    logic rx_s;

    sync_ff #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .d(sclk), .q(sclk_s)
    );
    sync_ff #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs_n (
        .clk(clk), .reset(reset), .d(cs_n), .q(cs_n_s)
    );
    sync_ff #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_rx (
        .clk(clk), .reset(reset), .d(rx), .q(rx_s)
    );

    state_t         state_q, state_d;
    logic           sclk_prev_q, sclk_prev_d;
    logic           sample_q, sample_d;
    logic           rx_smp_q, rx_smp_d;
    logic [W-1:0]   shift_q, shift_d;
    logic [5:0]     bits_left_q, bits_left_d;
    logic [W-1:0]   data_out_q, data_out_d;
    logic           data_valid_q, data_valid_d;
    logic           overflow_q, overflow_d;

    logic           sample_edge;
    logic           word_done;
    logic           accept;
    logic           drop;

    assign sample_edge = (sclk_s != sclk_prev_q) && (sclk_s == ~sample_falling);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable && !cs_n_s) state_d = SHIFT;
            SHIFT:   if (cs_n_s || !enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == SHIFT);
    end

    // The sample strobe and its data bit are registered together, so the shift
    // happens one cycle after the synchronized edge and completion one cycle later.
    always_comb begin
        sclk_prev_d  = sclk_s;
        sample_d     = sample_edge;
        rx_smp_d     = rx_s;
        shift_d      = shift_q;
        bits_left_d  = bits_left_q;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;

        word_done = (state_q == SHIFT) && (bits_left_q == 6'd0);
        accept    = data_valid_q && data_ready;
        drop      = word_done && data_valid_q && !data_ready;

        if (state_q == IDLE && state_d == SHIFT) begin
            bits_left_d = word_bits(word_len);
            shift_d     = '0;
        end else if (word_done) begin
            bits_left_d = word_bits(word_len);
            shift_d     = '0;
        end else if (state_q == SHIFT && sample_q) begin
            shift_d     = {shift_q[W-2:0], rx_smp_q};
            bits_left_d = bits_left_q - 6'd1;
        end

        // A completed word takes the slot only if it is empty or being drained now.
        if (word_done && !drop) begin
            data_out_d   = shift_q;
            data_valid_d = 1'b1;
        end else if (accept) begin
            data_valid_d = 1'b0;
        end

        overflow_d = drop | (overflow_q & ~ov_clear);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_prev_q  <= 1'b0;
            sample_q     <= 1'b0;
            rx_smp_q     <= 1'b0;
            shift_q      <= '0;
            bits_left_q  <= 6'd0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            sclk_prev_q  <= sclk_prev_d;
            sample_q     <= sample_d;
            rx_smp_q     <= rx_smp_d;
            shift_q      <= shift_d;
            bits_left_q  <= bits_left_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign overflow   = overflow_q;
    assign bits_left  = bits_left_q;

endmodule

// File: tb/tb_spi_rx_deserializer.sv
// Bench for spi_rx_deserializer: directed SPI frames plus random frames, checked
// every cycle against a word-arrival model of the receive path.
module tb_spi_rx_deserializer;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [4:0]  word_len;
    logic        sample_falling;
    logic        sclk;
    logic        cs_n;
    logic        rx;
    logic [31:0] data_out;
    logic        data_valid;
    logic        data_ready;
    logic        overflow;
    logic        ov_clear;
    logic        busy;
    logic [5:0]  bits_left;

    spi_rx_deserializer #(.SYNC_STAGES(S), .W(32)) dut (
        .clk(clk), .reset(reset), .enable(enable), .word_len(word_len),
        .sample_falling(sample_falling), .sclk(sclk), .cs_n(cs_n), .rx(rx),
        .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
        .overflow(overflow), .ov_clear(ov_clear), .busy(busy), .bits_left(bits_left)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] val;
    } arr_t;

    arr_t        arr_q[$];
    logic [31:0] got_q[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          chk_on = 0;
    bit          rand_mode = 0;
    bit          ready_on_arrival = 0;
    bit          clear_on_arrival = 0;
    int          last_final_cyc = 0;
    int          last_rise_cyc = 0;
    logic        prev_valid = 1'b0;
    logic        m_valid = 1'b0;
    logic [31:0] m_data = '0;
    logic        m_ovf = 1'b0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Output-port model: words arrive at fixed latency after their last sample edge.
    always @(posedge clk) begin
        bit hit;
        bit dropped;
        cyc++;
        dropped = 0;
        if (reset) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_ovf   = 1'b0;
            arr_q.delete();
        end else begin
            hit = (arr_q.size() > 0) && (arr_q[0].cyc == cyc);
            if (hit) begin
                if (m_valid && !data_ready) begin
                    dropped = 1;
                    m_ovf   = 1'b1;
                end else begin
                    m_data  = arr_q[0].val;
                    m_valid = 1'b1;
                end
                void'(arr_q.pop_front());
            end else if (m_valid && data_ready) begin
                m_valid = 1'b0;
            end
            if (ov_clear && !dropped) m_ovf = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check_output("cyc_valid", {31'b0, data_valid}, {31'b0, m_valid});
            check_output("cyc_data", data_out, m_data);
            check_output("cyc_overflow", {31'b0, overflow}, {31'b0, m_ovf});
            if (data_valid && data_ready) got_q.push_back(data_out);
            if (data_valid && !prev_valid) last_rise_cyc = cyc;
            prev_valid = data_valid;
        end
    end

    task automatic next_cycle(input int n);
        bit hit;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            if (rand_mode) begin
                data_ready = ($urandom_range(0, 3) != 0);
                ov_clear   = ($urandom_range(0, 15) == 0);
            end else begin
                hit = (arr_q.size() > 0) && (arr_q[0].cyc == cyc + 1);
                if (ready_on_arrival) data_ready = hit;
                if (clear_on_arrival) ov_clear = hit;
            end
        end
    endtask

    task automatic apply_stimulus(input logic [63:0] bits, input int nbits, input int h,
                                  input int change_at, input logic [4:0] new_len,
                                  input bit check_entry, input bit keep_cs);
        int          cur_len;
        int          cnt;
        logic [31:0] acc;
        logic        b;
        cur_len = int'(word_len) + 1;
        cnt     = 0;
        acc     = '0;
        cs_n    = 1'b0;
        next_cycle(h);
        if (check_entry) begin
            check_output("entry_busy", {31'b0, busy}, 32'd1);
            check_output("entry_bits_left", {26'b0, bits_left}, 32'(cur_len));
        end
        for (int i = 0; i < nbits; i++) begin
            if (i == change_at) word_len = new_len;
            b  = bits[nbits-1-i];
            rx = b;
            if (!sample_falling) begin
                next_cycle(h);
                sclk = 1'b1;
            end else begin
                sclk = 1'b1;
                next_cycle(h);
                sclk = 1'b0;
            end
            acc = {acc[30:0], b};
            cnt++;
            if (cnt == cur_len) begin
                arr_q.push_back('{cyc + 1 + S + 2, acc});
                last_final_cyc = cyc;
                acc     = '0;
                cnt     = 0;
                cur_len = int'(word_len) + 1;
            end
            if (!sample_falling) begin
                next_cycle(h);
                sclk = 1'b0;
            end else begin
                next_cycle(h);
            end
        end
        next_cycle(h);
        if (!keep_cs) begin
            cs_n = 1'b1;
            next_cycle(h + 4);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; word_len = 5'd7; sample_falling = 1'b0;
        sclk = 1'b0; cs_n = 1'b1; rx = 1'b0; data_ready = 1'b0; ov_clear = 1'b0;
        next_cycle(3);
        reset = 1'b0;
        next_cycle(1);
        chk_on = 1;
        check_output("reset_valid", {31'b0, data_valid}, 32'd0);
        check_output("reset_data", data_out, 32'd0);
        check_output("reset_overflow", {31'b0, overflow}, 32'd0);
        check_output("reset_busy", {31'b0, busy}, 32'd0);
        check_output("reset_bits_left", {26'b0, bits_left}, 32'd0);
        enable = 1'b1;

        $display("[TB] 8-bit word 0xA5");
        data_ready = 1'b1; got_q.delete();
        apply_stimulus(64'hA5, 8, 4, -1, 5'd0, 0, 0);
        next_cycle(6);
        check_output("a5_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) check_output("a5_data", got_q[0], 32'h000000A5);
        check_output("a5_latency", 32'(last_rise_cyc - last_final_cyc - 1), 32'(S + 2));
        check_output("a5_valid_drop", {31'b0, data_valid}, 32'd0);

        $display("[TB] 32-bit back-to-back");
        word_len = 5'd31; got_q.delete();
        apply_stimulus(64'hDEADBEEF_12345678, 64, 4, -1, 5'd0, 0, 0);
        next_cycle(6);
        check_output("b2b_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() > 1) begin
            check_output("b2b_first", got_q[0], 32'hDEADBEEF);
            check_output("b2b_second", got_q[1], 32'h12345678);
        end
        check_output("b2b_overflow", {31'b0, overflow}, 32'd0);

        $display("[TB] overflow");
        word_len = 5'd7; data_ready = 1'b0;
        apply_stimulus(64'h1122, 16, 4, -1, 5'd0, 0, 0);
        next_cycle(6);
        check_output("ovf_data", data_out, 32'h11);
        check_output("ovf_flag", {31'b0, overflow}, 32'd1);
        ov_clear = 1'b1;
        next_cycle(1);
        ov_clear = 1'b0;
        next_cycle(1);
        check_output("ovf_cleared", {31'b0, overflow}, 32'd0);
        check_output("ovf_data_kept", data_out, 32'h11);
        data_ready = 1'b1;
        next_cycle(2);

        $display("[TB] abort then 0x3C");
        apply_stimulus(64'h16, 5, 4, -1, 5'd0, 0, 0);
        check_output("abort_valid", {31'b0, data_valid}, 32'd0);
        check_output("abort_busy", {31'b0, busy}, 32'd0);
        got_q.delete();
        apply_stimulus(64'h3C, 8, 4, -1, 5'd0, 1, 0);
        next_cycle(6);
        check_output("abort_next_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) check_output("abort_next_data", got_q[0], 32'h3C);

        $display("[TB] falling-edge sampling and reset mid-word");
        sample_falling = 1'b1; data_ready = 1'b0;
        apply_stimulus(64'h5A, 8, 4, -1, 5'd0, 0, 0);
        next_cycle(6);
        check_output("fall_data", data_out, 32'h5A);
        apply_stimulus(64'h5, 3, 4, -1, 5'd0, 0, 1);
        reset = 1'b1; cs_n = 1'b1;
        next_cycle(1);
        check_output("midreset_valid", {31'b0, data_valid}, 32'd0);
        check_output("midreset_data", data_out, 32'd0);
        check_output("midreset_busy", {31'b0, busy}, 32'd0);
        check_output("midreset_bits_left", {26'b0, bits_left}, 32'd0);
        reset = 1'b0; sample_falling = 1'b0;
        next_cycle(6);

        $display("[TB] simultaneous accept/complete and overflow/clear");
        got_q.delete(); ready_on_arrival = 1;
        apply_stimulus(64'h3344, 16, 4, -1, 5'd0, 0, 0);
        next_cycle(6);
        ready_on_arrival = 0; data_ready = 1'b0;
        check_output("simul_accepted", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) check_output("simul_first", got_q[0], 32'h33);
        check_output("simul_data", data_out, 32'h44);
        check_output("simul_no_ovf", {31'b0, overflow}, 32'd0);
        clear_on_arrival = 1;
        apply_stimulus(64'h55, 8, 4, -1, 5'd0, 0, 0);
        next_cycle(6);
        clear_on_arrival = 0; ov_clear = 1'b0;
        check_output("setwins_ovf", {31'b0, overflow}, 32'd1);
        check_output("setwins_data", data_out, 32'h44);
        enable = 1'b0;
        next_cycle(4);
        check_output("disable_valid", {31'b0, data_valid}, 32'd1);
        check_output("disable_data", data_out, 32'h44);
        enable = 1'b1; ov_clear = 1'b1; data_ready = 1'b1;
        next_cycle(1);
        ov_clear = 1'b0;
        next_cycle(2);

        $display("[TB] word_len change mid-word");
        got_q.delete();
        apply_stimulus(64'hC39, 12, 3, 3, 5'd3, 0, 0);
        next_cycle(6);
        check_output("len_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() > 1) begin
            check_output("len_first", got_q[0], 32'hC3);
            check_output("len_second", got_q[1], 32'h9);
        end

        $display("[TB] random frames");
        rand_mode = 1;
        for (int f = 0; f < 8; f++) begin
            word_len       = 5'($urandom_range(0, 31));
            sample_falling = 1'($urandom_range(0, 1));
            apply_stimulus({$urandom(), $urandom()}, int'($urandom_range(1, 64)),
                           int'($urandom_range(2, 4)), -1, 5'd0, 0, 0);
        end
        rand_mode = 0; data_ready = 1'b1; ov_clear = 1'b0;
        next_cycle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
